add_sub_serial: RTL
===================

Name: add_sub_serial

Overview:
- Parametrised, multi-cycle adder/subtractor. Processes DIGIT bits per clock over WIDTH/DIGIT cycles.
- Successor to the fixed 16-bit combinational ripple adder/subtractor. Trades latency for area, adds a valid/ready handshake, carry/borrow-in, and a signed-overflow flag.
- Sits between the operand registers and the result writeback in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of DIGIT and ≥ DIGIT.
- DIGIT, 4, bits processed per cycle (slice width).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op present.
- in_ready  out  1  block can accept an operation.
- op  in  1  0 = ADD, 1 = SUB.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for ADD, borrow-in for SUB.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum/difference.
- co  out  1  carry-out. For SUB, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset (async, rst_n low): state = IDLE, in_ready = 0 while rst_n low, out_valid = 0, result = 0, co = 0, ovf = 0, internal shift registers and digit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On the edge where in_valid & in_ready: latch a; latch b (ADD) or ~b (SUB).
  - Initial carry = cin (ADD) or ~cin (SUB).
  - cnt = 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, add the lowest DIGIT bits of the A and B shift registers plus the carry register.
  - Shift the DIGIT-bit sum into the top of the result register (LSB-first fill). Shift A and B right by DIGIT.
  - Carry register takes the slice carry-out.
  - On the last slice (cnt = N-1, where N = WIDTH/DIGIT), also capture the carry into the MSB for the overflow computation.
  - Then go to DONE.
- DONE:
  - out_valid = 1; result, co and ovf are stable.
  - ovf = carry-into-MSB XOR carry-out-of-MSB.
  - On out_valid & out_ready, go to IDLE. out_valid drops on the next edge.
  - Holds indefinitely under backpressure; outputs must not change while waiting.
- Latency: if the operation is accepted at edge T, out_valid is high from edge T+N+1. The first op is accepted at T; a new op can be accepted no earlier than the edge after the result handshake.
- in_ready is a registered/state decode only. There is no combinational path from out_ready to in_ready.
- Arithmetic:
  - ADD: a + b + cin.
  - SUB: a - b - cin, computed as a + ~b + ~cin.
  - All arithmetic is modulo 2^WIDTH.
- DIGIT = WIDTH: single RUN cycle, so latency is 2 edges.
- Inputs are ignored outside IDLE. Changes to a/b/op after acceptance have no effect.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted and discarded; all outputs return to reset values immediately.

Optional Feature:
- Macro: ADD_SUB_SATURATE_EN.
- When defined, an input sat (1 bit) is added. If sat = 1 is latched at acceptance and ovf = 1, result is clamped:
  - positive overflow → 0x7F..F;
  - negative overflow → 0x80..0.
  - Sign is taken from a's MSB.
  - ovf still reports 1; co is unchanged.
- Without the macro: no sat port; result always wraps.

Decomposition:
- Shared package add_sub_pkg:
  - op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - FSM state encoding (2-bit) for IDLE/RUN/DONE.
- One sub-module: adder_digit, a DIGIT-bit ripple slice (a, b, cin → sum, cout, c_msb_in), instantiated once in the datapath.

Test Plan (WIDTH=16, DIGIT=4 unless noted):
- ADD 0x7FFF + 0x0001, cin=0 → result 0x8000, co=0, ovf=1; out_valid first high at T+5.
- SUB 0x0005 - 0x0007, cin=0 → result 0xFFFE, co=0 (borrow), ovf=0. SUB 0x1234 - 0x1234, cin=1 → 0xFFFF, co=0.
- Backpressure: out_ready held 0 for 10 cycles after done → out_valid, result and co stay stable; in_ready=0 throughout; in_valid pulses ignored; next op accepted only after the out_ready handshake.
- Reset mid-RUN (rst_n low at cnt=2) → out_valid, result, co and ovf = 0 immediately. After release, ADD 0xFFFF + 0x0001 → result 0x0000, co=1, ovf=0.
- DIGIT=16 build: ADD 0x00FF + 0x0F01 → result 0x1000, out_valid at T+2.
- ADD_SUB_SATURATE_EN, sat=1: ADD 0x7000 + 0x2000 → result 0x7FFF, ovf=1. SUB 0x8000 - 0x0001 → result 0x8000, ovf=1. With sat=0: ADD 0x7000 + 0x2000 → 0x9000.

Source files
------------

// File: rtl/add_sub_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Optional saturation is enabled with ADD_SUB_SATURATE_EN.
package add_sub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/add_sub_serial_if.sv
// Operand/result handshake bundle for add_sub_serial.
// The sat input only exists when ADD_SUB_SATURATE_EN is defined.
interface add_sub_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef ADD_SUB_SATURATE_EN
   logic             sat;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             co;
   logic             ovf;

   modport master (
      output in_valid, op, a, b, cin, out_ready,
`ifdef ADD_SUB_SATURATE_EN
      output sat,
`endif
      input  in_ready, out_valid, result, co, ovf
   );

   modport slave (
      input  in_valid, op, a, b, cin, out_ready,
`ifdef ADD_SUB_SATURATE_EN
      input  sat,
`endif
      output in_ready, out_valid, result, co, ovf
   );
endinterface

// File: rtl/add_sub_serial_adder_digit.sv
// DIGIT-bit ripple slice. Also exposes the carry into its top bit so the
// caller can form signed overflow on the most significant slice.
module adder_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_cin,
   output logic [DIGIT-1:0] o_sum,
   output logic             o_cout,
   output logic             o_c_msb_in
);
   logic [DIGIT:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < DIGIT; g++) begin : g_bit
      assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout     = w_c[DIGIT];
   assign o_c_msb_in = w_c[DIGIT-1];
endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: WIDTH/DIGIT slice cycles per operation,
// valid/ready on both sides, signed overflow flag.
// Define ADD_SUB_SATURATE_EN to add clamping on overflow via the sat input.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// RUN   | one DIGIT-bit slice per cycle, LSB slice first
// DONE  | result held; out_valid rises one cycle after entry
module add_sub_serial
   import add_sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   add_sub_serial_if.slave    bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_co;
   logic             r_ovf;
   logic             r_out_valid;
   logic             r_in_ready;
   logic             r_a_msb;
`ifdef ADD_SUB_SATURATE_EN
   logic             r_sat;
`endif

   logic [DIGIT-1:0]       w_sum;
   logic                   w_cout;
   logic                   w_c_msb_in;
   logic                   w_accept;
   logic                   w_last;
   logic                   w_ovf;
   logic [WIDTH+DIGIT-1:0] w_cat;
   logic [WIDTH-1:0]       w_acc_nxt;
   logic [WIDTH-1:0]       w_final;

   adder_digit #(.DIGIT(DIGIT)) u_digit (
      .i_a        (r_a[DIGIT-1:0]),
      .i_b        (r_b[DIGIT-1:0]),
      .i_cin      (r_carry),
      .o_sum      (w_sum),
      .o_cout     (w_cout),
      .o_c_msb_in (w_c_msb_in)
   );

   assign w_accept  = (r_state == ST_IDLE) & bus.in_valid & r_in_ready;
   assign w_last    = (r_cnt == CW'(N - 1));
   assign w_ovf     = w_c_msb_in ^ w_cout;
   // New slice enters at the top; after N slices the first one sits at the LSB.
   assign w_cat     = {w_sum, r_acc};
   assign w_acc_nxt = w_cat[WIDTH+DIGIT-1:DIGIT];

   // Saturation clamp (sign of the true result follows operand A on overflow).
   always_comb begin
      w_final = w_acc_nxt;
`ifdef ADD_SUB_SATURATE_EN
      if (r_sat && w_ovf)
         w_final = r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)                       w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)                         w_state_nxt = ST_DONE;
         ST_DONE: if (r_out_valid && bus.out_ready)   w_state_nxt = ST_IDLE;
         default:                                     w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake flags are registered so neither depends combinationally on the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (r_state == ST_DONE) && !(r_out_valid && bus.out_ready);
      end
   end

   // Operand load on acceptance, slice shifting during RUN, result capture on the last slice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_co     <= 1'b0;
         r_ovf    <= 1'b0;
         r_a_msb  <= 1'b0;
`ifdef ADD_SUB_SATURATE_EN
         r_sat    <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a      <= bus.a;
         r_b      <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
         r_carry  <= (bus.op == OP_SUB) ? ~bus.cin : bus.cin;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_a_msb  <= bus.a[WIDTH-1];
`ifdef ADD_SUB_SATURATE_EN
         r_sat    <= bus.sat;
`endif
      end else if (r_state == ST_RUN) begin
         r_a     <= r_a >> DIGIT;
         r_b     <= r_b >> DIGIT;
         r_acc   <= w_acc_nxt;
         r_carry <= w_cout;
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            r_result <= w_final;
            r_co     <= w_cout;
            r_ovf    <= w_ovf;
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.co        = r_co;
   assign bus.ovf       = r_ovf;
endmodule
